// File: rtl/sport0_abuf_ctl.sv
// sport0_abuf_ctl: SPORT0 autobuffer controller. Moves RX/TX words between SPORT0 and a
// shared memory port using per-direction circular pointers, RX-priority arbitration.
`default_nettype none

module sport0_abuf_ctl #(
  parameter int AW = 14,
  parameter int DW = 16
) (
  input  logic          DSPCLK,
  input  logic          RST_,
  input  logic          ABUF_EN,
  input  logic          RX_REQ,
  input  logic [DW-1:0] RX_DATA,
  input  logic          TX_REQ,
  input  logic [AW-1:0] RX_BASE,
  input  logic [AW-1:0] TX_BASE,
  input  logic [AW-1:0] RX_LEN,
  input  logic [AW-1:0] TX_LEN,
  input  logic [AW-1:0] RX_STEP,
  input  logic [AW-1:0] TX_STEP,
  output logic          MEM_REQ,
  output logic          MEM_WR,
  output logic [AW-1:0] MEM_ADDR,
  output logic [DW-1:0] MEM_WDATA,
  input  logic          MEM_GNT,
  input  logic [DW-1:0] MEM_RDATA,
  output logic [DW-1:0] TX_DATA,
  output logic          TX_LD,
  output logic          RX_IRQ,
  output logic          TX_IRQ,
  output logic          RX_OVF,
  output logic          TX_UNF
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    RX_ACC = 2'd1,
    TX_ACC = 2'd2,
    TX_RD  = 2'd3
  } state_t;

  state_t r_state, w_state_nxt;

  logic          r_en_d;
  logic [AW-1:0] r_rx_base, r_tx_base, r_rx_len, r_tx_len, r_rx_step, r_tx_step;
  logic [AW-1:0] r_rx_off, r_tx_off;
  logic [DW-1:0] r_rx_hold;
  logic          r_rx_pend, r_tx_pend;

  logic          w_en_rise;
  logic          w_start_rx, w_start_tx, w_rx_adv, w_tx_adv, w_tx_ld;
  logic [AW:0]   w_rx_a, w_tx_a;

  // Returns {wrapped, next_offset}; relies on STEP <= LEN so one subtraction suffices.
  function automatic logic [AW:0] f_adv(input logic [AW-1:0] off,
                                        input logic [AW-1:0] step,
                                        input logic [AW-1:0] len);
    logic [AW:0]   n;
    logic [AW-1:0] d;
    n = {1'b0, off} + {1'b0, step};
    d = n[AW-1:0] - len;
    if (len == '0)
      f_adv = {1'b0, n[AW-1:0]};
    else if (n >= {1'b0, len})
      f_adv = {1'b1, d};
    else
      f_adv = {1'b0, n[AW-1:0]};
  endfunction

  assign w_en_rise = ABUF_EN & ~r_en_d;
  assign w_rx_a    = f_adv(r_rx_off, r_rx_step, r_rx_len);
  assign w_tx_a    = f_adv(r_tx_off, r_tx_step, r_tx_len);
  assign MEM_WDATA = r_rx_hold;

  always_ff @(posedge DSPCLK or negedge RST_) begin
    if (!RST_) r_state <= IDLE;
    else       r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    w_start_rx  = 1'b0;
    w_start_tx  = 1'b0;
    w_rx_adv    = 1'b0;
    w_tx_adv    = 1'b0;
    w_tx_ld     = 1'b0;
    case (r_state)
      IDLE: begin
        if (ABUF_EN && r_rx_pend) begin
          w_state_nxt = RX_ACC;
          w_start_rx  = 1'b1;
        end else if (ABUF_EN && r_tx_pend) begin
          w_state_nxt = TX_ACC;
          w_start_tx  = 1'b1;
        end
      end
      RX_ACC: if (MEM_GNT) begin
        w_state_nxt = IDLE;
        w_rx_adv    = 1'b1;
      end
      TX_ACC: if (MEM_GNT) begin
        w_state_nxt = TX_RD;
        w_tx_adv    = 1'b1;
      end
      TX_RD: begin
        w_state_nxt = IDLE;
        w_tx_ld     = 1'b1;
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge DSPCLK or negedge RST_) begin
    if (!RST_) begin
      r_en_d    <= 1'b0;
      r_rx_base <= '0;
      r_tx_base <= '0;
      r_rx_len  <= '0;
      r_tx_len  <= '0;
      r_rx_step <= '0;
      r_tx_step <= '0;
      r_rx_off  <= '0;
      r_tx_off  <= '0;
      r_rx_hold <= '0;
      r_rx_pend <= 1'b0;
      r_tx_pend <= 1'b0;
      RX_OVF    <= 1'b0;
      TX_UNF    <= 1'b0;
      RX_IRQ    <= 1'b0;
      TX_IRQ    <= 1'b0;
      MEM_REQ   <= 1'b0;
      MEM_WR    <= 1'b0;
      MEM_ADDR  <= '0;
      TX_DATA   <= '0;
      TX_LD     <= 1'b0;
    end else begin
      r_en_d <= ABUF_EN;
      if (w_en_rise) begin
        r_rx_base <= RX_BASE;
        r_tx_base <= TX_BASE;
        r_rx_len  <= RX_LEN;
        r_tx_len  <= TX_LEN;
        r_rx_step <= RX_STEP;
        r_tx_step <= TX_STEP;
        r_rx_off  <= '0;
        r_tx_off  <= '0;
      end else begin
        if (w_rx_adv) r_rx_off <= w_rx_a[AW-1:0];
        if (w_tx_adv) r_tx_off <= w_tx_a[AW-1:0];
      end
      RX_IRQ <= w_rx_adv & w_rx_a[AW];
      TX_IRQ <= w_tx_adv & w_tx_a[AW];

      if (RX_REQ) r_rx_hold <= RX_DATA;
      // Once idle with the block disabled, queued requests are discarded.
      if (!ABUF_EN && r_state == IDLE) begin
        r_rx_pend <= 1'b0;
        r_tx_pend <= 1'b0;
      end else begin
        if (RX_REQ)        r_rx_pend <= 1'b1;
        else if (w_rx_adv) r_rx_pend <= 1'b0;
        if (TX_REQ)        r_tx_pend <= 1'b1;
        else if (w_tx_adv) r_tx_pend <= 1'b0;
      end

      if (!ABUF_EN) begin
        RX_OVF <= 1'b0;
        TX_UNF <= 1'b0;
      end else begin
        if (RX_REQ && r_rx_pend) RX_OVF <= 1'b1;
        if (TX_REQ && r_tx_pend) TX_UNF <= 1'b1;
      end

      if (w_start_rx) begin
        MEM_REQ  <= 1'b1;
        MEM_WR   <= 1'b1;
        MEM_ADDR <= r_rx_base + r_rx_off;
      end else if (w_start_tx) begin
        MEM_REQ  <= 1'b1;
        MEM_WR   <= 1'b0;
        MEM_ADDR <= r_tx_base + r_tx_off;
      end else if (w_rx_adv || w_tx_adv) begin
        MEM_REQ <= 1'b0;
        MEM_WR  <= 1'b0;
      end

      TX_LD <= w_tx_ld;
      if (w_tx_ld) TX_DATA <= MEM_RDATA;
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_sport0_abuf_ctl.sv
// tb_sport0_abuf_ctl: directed, table-driven self-checking bench for sport0_abuf_ctl.
`default_nettype none

module tb_sport0_abuf_ctl;
  localparam int AW = 14;
  localparam int DW = 16;

  logic          DSPCLK = 1'b0;
  logic          RST_;
  logic          ABUF_EN, RX_REQ, TX_REQ, MEM_GNT;
  logic [DW-1:0] RX_DATA, MEM_RDATA;
  logic [AW-1:0] RX_BASE, TX_BASE, RX_LEN, TX_LEN, RX_STEP, TX_STEP;
  logic          MEM_REQ, MEM_WR, TX_LD, RX_IRQ, TX_IRQ, RX_OVF, TX_UNF;
  logic [AW-1:0] MEM_ADDR;
  logic [DW-1:0] MEM_WDATA, TX_DATA;

  int n_cmp = 0;
  int n_fail = 0;

  sport0_abuf_ctl #(.AW(AW), .DW(DW)) dut (
    .DSPCLK(DSPCLK), .RST_(RST_), .ABUF_EN(ABUF_EN),
    .RX_REQ(RX_REQ), .RX_DATA(RX_DATA), .TX_REQ(TX_REQ),
    .RX_BASE(RX_BASE), .TX_BASE(TX_BASE), .RX_LEN(RX_LEN), .TX_LEN(TX_LEN),
    .RX_STEP(RX_STEP), .TX_STEP(TX_STEP),
    .MEM_REQ(MEM_REQ), .MEM_WR(MEM_WR), .MEM_ADDR(MEM_ADDR), .MEM_WDATA(MEM_WDATA),
    .MEM_GNT(MEM_GNT), .MEM_RDATA(MEM_RDATA),
    .TX_DATA(TX_DATA), .TX_LD(TX_LD), .RX_IRQ(RX_IRQ), .TX_IRQ(TX_IRQ),
    .RX_OVF(RX_OVF), .TX_UNF(TX_UNF)
  );

  always #5 DSPCLK = ~DSPCLK;

  typedef struct {
    logic [DW-1:0] data;
    logic [AW-1:0] addr;
    logic          irq;
  } rx_vec_t;

  rx_vec_t tab_rx[6];
  rx_vec_t tab_wrap[3];

  task automatic tick();
    @(posedge DSPCLK);
    #1;
  endtask

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: actual=%0h required=%0h", nm, act, exp);
    end
  endtask

  // One RX word with MEM_GNT high: request, write issue, grant, then idle padding.
  task automatic rx_xfer(input rx_vec_t v);
    RX_REQ = 1'b1;
    RX_DATA = v.data;
    tick();
    RX_REQ = 1'b0;
    chk("rx_req_wait", {31'd0, MEM_REQ}, 32'd0);
    tick();
    chk("rx_req", {31'd0, MEM_REQ}, 32'd1);
    chk("rx_wr", {31'd0, MEM_WR}, 32'd1);
    chk("rx_addr", {18'd0, MEM_ADDR}, {18'd0, v.addr});
    chk("rx_wdata", {16'd0, MEM_WDATA}, {16'd0, v.data});
    tick();
    chk("rx_req_drop", {31'd0, MEM_REQ}, 32'd0);
    chk("rx_irq", {31'd0, RX_IRQ}, {31'd0, v.irq});
    tick();
    chk("rx_irq_end", {31'd0, RX_IRQ}, 32'd0);
    repeat (4) tick();
  endtask

  task automatic tx_xfer(input logic [DW-1:0] rd, input logic [AW-1:0] addr);
    MEM_RDATA = rd;
    TX_REQ = 1'b1;
    tick();
    TX_REQ = 1'b0;
    tick();
    chk("tx_req", {31'd0, MEM_REQ}, 32'd1);
    chk("tx_wr", {31'd0, MEM_WR}, 32'd0);
    chk("tx_addr", {18'd0, MEM_ADDR}, {18'd0, addr});
    tick();
    chk("tx_req_drop", {31'd0, MEM_REQ}, 32'd0);
    chk("tx_ld_early", {31'd0, TX_LD}, 32'd0);
    chk("tx_irq", {31'd0, TX_IRQ}, 32'd0);
    tick();
    chk("tx_ld", {31'd0, TX_LD}, 32'd1);
    chk("tx_data", {16'd0, TX_DATA}, {16'd0, rd});
    tick();
    chk("tx_ld_end", {31'd0, TX_LD}, 32'd0);
    repeat (2) tick();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: actual=timeout required=finish");
    $fatal(1);
  end

  initial begin
    tab_rx[0] = '{16'h00A0, 14'h100, 1'b0};
    tab_rx[1] = '{16'h00A1, 14'h101, 1'b0};
    tab_rx[2] = '{16'h00A2, 14'h102, 1'b0};
    tab_rx[3] = '{16'h00A3, 14'h103, 1'b1};
    tab_rx[4] = '{16'h00A4, 14'h100, 1'b0};
    tab_rx[5] = '{16'h00A5, 14'h101, 1'b0};
    tab_wrap[0] = '{16'h00E0, 14'h300, 1'b1};
    tab_wrap[1] = '{16'h00E1, 14'h300, 1'b1};
    tab_wrap[2] = '{16'h00E2, 14'h300, 1'b1};

    RST_ = 1'b0; ABUF_EN = 1'b0; RX_REQ = 1'b0; TX_REQ = 1'b0; MEM_GNT = 1'b1;
    RX_DATA = '0; MEM_RDATA = '0;
    RX_BASE = 14'h100; RX_LEN = 14'd4; RX_STEP = 14'd1;
    TX_BASE = 14'h200; TX_LEN = 14'd0; TX_STEP = 14'd2;
    repeat (3) tick();
    chk("rst_req", {31'd0, MEM_REQ}, 32'd0);
    chk("rst_addr", {18'd0, MEM_ADDR}, 32'd0);
    chk("rst_wdata", {16'd0, MEM_WDATA}, 32'd0);
    chk("rst_flags", {26'd0, MEM_WR, TX_LD, RX_IRQ, TX_IRQ, RX_OVF, TX_UNF}, 32'd0);
    chk("rst_txdata", {16'd0, TX_DATA}, 32'd0);
    RST_ = 1'b1;
    tick();
    ABUF_EN = 1'b1;
    tick();

    for (int i = 0; i < 6; i++) rx_xfer(tab_rx[i]);

    tx_xfer(16'h1234, 14'h200);
    tx_xfer(16'h5678, 14'h202);

    // Simultaneous RX/TX with a 3-cycle grant delay on the write.
    MEM_GNT = 1'b0;
    RX_REQ = 1'b1; TX_REQ = 1'b1; RX_DATA = 16'h00B0; MEM_RDATA = 16'h9ABC;
    tick();
    RX_REQ = 1'b0; TX_REQ = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("sim_rx_req", {31'd0, MEM_REQ}, 32'd1);
      chk("sim_rx_wr", {31'd0, MEM_WR}, 32'd1);
      chk("sim_rx_addr", {18'd0, MEM_ADDR}, 32'h102);
    end
    MEM_GNT = 1'b1;
    tick();
    chk("sim_rx_drop", {31'd0, MEM_REQ}, 32'd0);
    tick();
    chk("sim_tx_req", {31'd0, MEM_REQ}, 32'd1);
    chk("sim_tx_wr", {31'd0, MEM_WR}, 32'd0);
    chk("sim_tx_addr", {18'd0, MEM_ADDR}, 32'h204);
    tick();
    tick();
    chk("sim_tx_ld", {31'd0, TX_LD}, 32'd1);
    chk("sim_tx_data", {16'd0, TX_DATA}, 32'h9ABC);
    chk("sim_no_flags", {30'd0, RX_OVF, TX_UNF}, 32'd0);
    repeat (2) tick();

    // RX overflow: second word overwrites the held one before the grant.
    MEM_GNT = 1'b0;
    RX_REQ = 1'b1; RX_DATA = 16'h00C0;
    tick();
    RX_REQ = 1'b0;
    tick();
    chk("ovf_req", {31'd0, MEM_REQ}, 32'd1);
    chk("ovf_wdata1", {16'd0, MEM_WDATA}, 32'h00C0);
    chk("ovf_clear", {31'd0, RX_OVF}, 32'd0);
    RX_REQ = 1'b1; RX_DATA = 16'h00C1;
    tick();
    RX_REQ = 1'b0;
    chk("ovf_set", {31'd0, RX_OVF}, 32'd1);
    chk("ovf_wdata2", {16'd0, MEM_WDATA}, 32'h00C1);
    chk("ovf_addr", {18'd0, MEM_ADDR}, 32'h103);
    MEM_GNT = 1'b1;
    tick();
    chk("ovf_drop", {31'd0, MEM_REQ}, 32'd0);
    repeat (3) begin
      tick();
      chk("ovf_single", {31'd0, MEM_REQ}, 32'd0);
    end
    chk("ovf_sticky", {31'd0, RX_OVF}, 32'd1);
    ABUF_EN = 1'b0;
    tick();
    chk("ovf_en_clr", {31'd0, RX_OVF}, 32'd0);

    // Re-enable with STEP == LEN: every access wraps back to base.
    RX_BASE = 14'h300; RX_LEN = 14'd3; RX_STEP = 14'd3;
    ABUF_EN = 1'b1;
    tick();
    for (int i = 0; i < 3; i++) rx_xfer(tab_wrap[i]);

    // Disable during a stalled RX access; the queued TX request must be dropped.
    MEM_GNT = 1'b0;
    RX_REQ = 1'b1; RX_DATA = 16'h00D0;
    tick();
    RX_REQ = 1'b0;
    tick();
    chk("dis_req", {31'd0, MEM_REQ}, 32'd1);
    ABUF_EN = 1'b0; TX_REQ = 1'b1;
    tick();
    TX_REQ = 1'b0;
    chk("dis_hold1", {31'd0, MEM_REQ}, 32'd1);
    tick();
    chk("dis_hold2", {31'd0, MEM_REQ}, 32'd1);
    MEM_GNT = 1'b1;
    tick();
    chk("dis_drop", {31'd0, MEM_REQ}, 32'd0);
    repeat (3) tick();
    ABUF_EN = 1'b1;
    repeat (4) begin
      tick();
      chk("dis_tx_gone", {31'd0, MEM_REQ}, 32'd0);
    end

    // Asynchronous reset in the middle of a TX access.
    MEM_GNT = 1'b0;
    TX_REQ = 1'b1;
    tick();
    TX_REQ = 1'b0;
    tick();
    chk("ar_req", {31'd0, MEM_REQ}, 32'd1);
    chk("ar_wr", {31'd0, MEM_WR}, 32'd0);
    #2;
    RST_ = 1'b0;
    #1;
    chk("ar_req_async", {31'd0, MEM_REQ}, 32'd0);
    chk("ar_addr", {18'd0, MEM_ADDR}, 32'd0);
    tick();
    RST_ = 1'b1;
    tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
